// File: rtl/preg_release_queue_if.sv
// ---------------------------------------------------------------------------
// preg_release_queue_if
// Purpose: bundles the commit-side release handshake, the free-list drain
//          lanes and the queue status/error flags of preg_release_queue.
// Signals:
//   rel_valid[IN_PORTS]          release request per commit lane
//   rel_phys[IN_PORTS][TAG_W]    tag to release per lane
//   rel_ready                    queue can take a full IN_PORTS group
//   drain_hold                   1 = suppress draining
//   free_en[OUT_PORTS]           free-list enable per lane
//   free_phys[OUT_PORTS][TAG_W]  freed tag per lane
//   count, empty                 occupancy
//   overflow_err, range_err, dbl_free_err   sticky error flags
// Modports: master = commit/free-list environment, slave = the queue.
// ---------------------------------------------------------------------------
interface preg_release_queue_if #(
    parameter int unsigned TAG_W     = 6,
    parameter int unsigned IN_PORTS  = 2,
    parameter int unsigned OUT_PORTS = 2,
    parameter int unsigned DEPTH     = 16
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [IN_PORTS-1:0]             rel_valid;
    logic [IN_PORTS-1:0][TAG_W-1:0]  rel_phys;
    logic                            rel_ready;
    logic                            drain_hold;
    logic [OUT_PORTS-1:0]            free_en;
    logic [OUT_PORTS-1:0][TAG_W-1:0] free_phys;
    logic [CNT_W-1:0]                count;
    logic                            empty;
    logic                            overflow_err;
    logic                            range_err;
    logic                            dbl_free_err;

    modport master (
        output rel_valid, rel_phys, drain_hold,
        input  rel_ready, free_en, free_phys, count, empty,
               overflow_err, range_err, dbl_free_err
    );

    modport slave (
        input  rel_valid, rel_phys, drain_hold,
        output rel_ready, free_en, free_phys, count, empty,
               overflow_err, range_err, dbl_free_err
    );
endinterface

// File: rtl/preg_release_queue.sv
// ---------------------------------------------------------------------------
// preg_release_queue
// Purpose: buffers physical-register tags retired by commit (up to IN_PORTS
//          per cycle) and drains them FIFO into the free list release ports
//          (up to OUT_PORTS per cycle). Drain can be held during recovery.
// Ports:
//   clk    core clock, rising edge
//   reset  asynchronous, active-high
//   bus    preg_release_queue_if.slave (release lanes, drain hold, free lanes,
//          count/empty, sticky overflow/range/double-free errors)
// Option: define RELQ_DBL_FREE_CHECK_EN to add a pending-tag bitmap that
//         blocks double releases and reports them on dbl_free_err; when
//         undefined duplicates pass through and dbl_free_err is tied to 0.
// ---------------------------------------------------------------------------
module preg_release_queue #(
    parameter int unsigned PHYS_REGS = 48,
    parameter int unsigned TAG_W     = 6,
    parameter int unsigned IN_PORTS  = 2,
    parameter int unsigned OUT_PORTS = 2,
    parameter int unsigned DEPTH     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    preg_release_queue_if.slave  bus
);
    localparam int unsigned      PTR_W     = $clog2(DEPTH);
    localparam int unsigned      CNT_W     = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] OUT_MAX   = CNT_W'(OUT_PORTS);
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - IN_PORTS);

    logic [TAG_W-1:0]                mem [DEPTH];
    logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]                count_q, count_d, n_in, n_out;
    logic                            rel_ready_q, rel_ready_d;
    logic                            empty_q, empty_d;
    logic [OUT_PORTS-1:0]            free_en_q, free_en_d;
    logic [OUT_PORTS-1:0][TAG_W-1:0] free_phys_q, free_phys_d;
    logic                            ovf_q, ovf_d, range_q, range_d;
    logic                            range_hit;
    logic [IN_PORTS-1:0]             lane_acc;
    logic [IN_PORTS-1:0][PTR_W-1:0]  lane_idx;

`ifdef RELQ_DBL_FREE_CHECK_EN
    logic [PHYS_REGS-1:0] pending_q, pending_d;
    logic                 dbl_q, dbl_d, dbl_hit, lane_dup;
`endif

    // Drain selection: uses pre-edge count so same-cycle enqueues never leave.
    always_comb begin
        n_out       = '0;
        free_en_d   = '0;
        free_phys_d = '0;
        if (!bus.drain_hold) begin
            n_out = (count_q < OUT_MAX) ? count_q : OUT_MAX;
        end
        for (int k = 0; k < OUT_PORTS; k++) begin
            if (CNT_W'(k) < n_out) begin
                free_en_d[k]   = 1'b1;
                free_phys_d[k] = mem[rd_ptr_q + PTR_W'(k)];
            end
        end
    end

    // Enqueue: filter lanes, then compact accepted ones in lane order.
    always_comb begin
        n_in      = '0;
        lane_acc  = '0;
        lane_idx  = '0;
        range_hit = 1'b0;
`ifdef RELQ_DBL_FREE_CHECK_EN
        dbl_hit   = 1'b0;
        lane_dup  = 1'b0;
`endif
        for (int i = 0; i < IN_PORTS; i++) begin
            if (bus.rel_valid[i]) begin
                if (32'(bus.rel_phys[i]) >= PHYS_REGS) begin
                    range_hit = 1'b1;
                end else if (rel_ready_q) begin
`ifdef RELQ_DBL_FREE_CHECK_EN
                    // Already queued, or already accepted on a lower lane this cycle.
                    lane_dup = pending_q[bus.rel_phys[i]];
                    for (int j = 0; j < IN_PORTS; j++) begin
                        if (j < i && lane_acc[j] && bus.rel_phys[j] == bus.rel_phys[i]) begin
                            lane_dup = 1'b1;
                        end
                    end
                    if (lane_dup) begin
                        dbl_hit = 1'b1;
                    end else begin
                        lane_acc[i] = 1'b1;
                        lane_idx[i] = wr_ptr_q + PTR_W'(n_in);
                        n_in        = n_in + CNT_W'(1);
                    end
`else
                    lane_acc[i] = 1'b1;
                    lane_idx[i] = wr_ptr_q + PTR_W'(n_in);
                    n_in        = n_in + CNT_W'(1);
`endif
                end
            end
        end
    end

    // Pointer, occupancy and status next-state.
    always_comb begin
        count_d     = count_q + n_in - n_out;
        wr_ptr_d    = wr_ptr_q + PTR_W'(n_in);
        rd_ptr_d    = rd_ptr_q + PTR_W'(n_out);
        rel_ready_d = (count_d <= READY_MAX);
        empty_d     = (count_d == '0);
        ovf_d       = ovf_q | (!rel_ready_q && (|bus.rel_valid));
        range_d     = range_q | range_hit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            rel_ready_q <= 1'b1;
            empty_q     <= 1'b1;
            free_en_q   <= '0;
            free_phys_q <= '0;
            ovf_q       <= 1'b0;
            range_q     <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            rel_ready_q <= rel_ready_d;
            empty_q     <= empty_d;
            free_en_q   <= free_en_d;
            free_phys_q <= free_phys_d;
            ovf_q       <= ovf_d;
            range_q     <= range_d;
        end
    end

    // Storage array; contents are don't-care outside the occupied window.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_PORTS; i++) begin
            if (lane_acc[i]) begin
                mem[lane_idx[i]] <= bus.rel_phys[i];
            end
        end
    end

`ifdef RELQ_DBL_FREE_CHECK_EN
    // Pending bitmap: cleared as a tag is handed to the free list, set on enqueue.
    always_comb begin
        pending_d = pending_q;
        for (int k = 0; k < OUT_PORTS; k++) begin
            if (free_en_d[k]) begin
                pending_d[free_phys_d[k]] = 1'b0;
            end
        end
        for (int i = 0; i < IN_PORTS; i++) begin
            if (lane_acc[i]) begin
                pending_d[bus.rel_phys[i]] = 1'b1;
            end
        end
        dbl_d = dbl_q | dbl_hit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            dbl_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            dbl_q     <= dbl_d;
        end
    end

    assign bus.dbl_free_err = dbl_q;
`else
    assign bus.dbl_free_err = 1'b0;
`endif

    assign bus.rel_ready    = rel_ready_q;
    assign bus.free_en      = free_en_q;
    assign bus.free_phys    = free_phys_q;
    assign bus.count        = count_q;
    assign bus.empty        = empty_q;
    assign bus.overflow_err = ovf_q;
    assign bus.range_err    = range_q;
endmodule

// File: tb/tb_preg_release_queue.sv
// ---------------------------------------------------------------------------
// tb_preg_release_queue
// Purpose: directed, self-checking bench for preg_release_queue. A table of
//          per-cycle vectors covers basic release, compaction, range drops
//          and drain hold; hand-written sequences cover full/overflow with
//          pointer wrap, async reset mid-burst and double-release handling
//          (expectations follow RELQ_DBL_FREE_CHECK_EN).
// ---------------------------------------------------------------------------
module tb_preg_release_queue;
    localparam int unsigned TAG_W     = 6;
    localparam int unsigned IN_PORTS  = 2;
    localparam int unsigned OUT_PORTS = 2;
    localparam int unsigned DEPTH     = 16;

    logic clk = 1'b0;
    logic reset;

    preg_release_queue_if #(
        .TAG_W(TAG_W), .IN_PORTS(IN_PORTS), .OUT_PORTS(OUT_PORTS), .DEPTH(DEPTH)
    ) bus ();

    preg_release_queue #(
        .PHYS_REGS(48), .TAG_W(TAG_W), .IN_PORTS(IN_PORTS),
        .OUT_PORTS(OUT_PORTS), .DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0] v;
        int         p0;
        int         p1;
        logic       hold;
        logic [1:0] en;
        int         f0;
        int         f1;
        int         cnt;
        logic       rdy;
        logic       emp;
        logic       rerr;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input int p0, input int p1, input logic hold);
        bus.rel_valid    = v;
        bus.rel_phys[0]  = TAG_W'(p0);
        bus.rel_phys[1]  = TAG_W'(p1);
        bus.drain_hold   = hold;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int hits;
    int exp_q2;
    int exp_dbl;
    int exp_hits;
    int exp_dup_cnt;
    int exp_dup_en;

    initial begin
        //           v      p0  p1  h     en     f0  f1 cnt rdy  emp  rerr
        vecs[0]  = '{2'b11, 33, 40, 1'b0, 2'b00,  0,  0, 2, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{2'b00,  0,  0, 1'b0, 2'b11, 33, 40, 0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{2'b10,  0, 35, 1'b0, 2'b00,  0,  0, 1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{2'b11, 36, 37, 1'b0, 2'b01, 35,  0, 2, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{2'b00,  0,  0, 1'b0, 2'b11, 36, 37, 0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{2'b00,  0,  0, 1'b0, 2'b00,  0,  0, 0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{2'b01, 50,  0, 1'b0, 2'b00,  0,  0, 0, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{2'b11, 50, 20, 1'b0, 2'b00,  0,  0, 1, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{2'b00,  0,  0, 1'b1, 2'b00,  0,  0, 1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{2'b00,  0,  0, 1'b0, 2'b01, 20,  0, 0, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{2'b11,  1,  2, 1'b1, 2'b00,  0,  0, 2, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{2'b11,  3,  4, 1'b0, 2'b11,  1,  2, 2, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{2'b00,  0,  0, 1'b1, 2'b00,  0,  0, 2, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{2'b00,  0,  0, 1'b0, 2'b11,  3,  4, 0, 1'b1, 1'b1, 1'b1};

`ifdef RELQ_DBL_FREE_CHECK_EN
        exp_q2 = 1; exp_dbl = 1; exp_hits = 1; exp_dup_cnt = 1; exp_dup_en = 1;
`else
        exp_q2 = 2; exp_dbl = 0; exp_hits = 2; exp_dup_cnt = 2; exp_dup_en = 3;
`endif

        // Power-on reset state
        reset = 1'b1;
        drive(2'b00, 0, 0, 1'b0);
        #1;
        check("por.free_en", int'(bus.free_en), 0);
        check("por.count", int'(bus.count), 0);
        check("por.rel_ready", int'(bus.rel_ready), 1);
        check("por.empty", int'(bus.empty), 1);
        @(negedge clk);
        reset = 1'b0;

        // Table: basic, compaction/order, range drop, drain hold
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].v, vecs[i].p0, vecs[i].p1, vecs[i].hold);
            tick();
            check($sformatf("vec%0d.free_en", i), int'(bus.free_en), int'(vecs[i].en));
            check($sformatf("vec%0d.free_phys0", i), int'(bus.free_phys[0]), vecs[i].f0);
            check($sformatf("vec%0d.free_phys1", i), int'(bus.free_phys[1]), vecs[i].f1);
            check($sformatf("vec%0d.count", i), int'(bus.count), vecs[i].cnt);
            check($sformatf("vec%0d.rel_ready", i), int'(bus.rel_ready), int'(vecs[i].rdy));
            check($sformatf("vec%0d.empty", i), int'(bus.empty), int'(vecs[i].emp));
            check($sformatf("vec%0d.range_err", i), int'(bus.range_err), int'(vecs[i].rerr));
        end

        // Full queue with pointers starting mid-array, overflow, then wrap drain
        for (int i = 0; i < 8; i++) begin
            drive(2'b11, 2 * i, 2 * i + 1, 1'b1);
            tick();
        end
        check("full.count", int'(bus.count), 16);
        check("full.rel_ready", int'(bus.rel_ready), 0);
        check("full.overflow_pre", int'(bus.overflow_err), 0);
        drive(2'b11, 20, 21, 1'b1);
        tick();
        check("full.overflow_err", int'(bus.overflow_err), 1);
        check("full.count_after_ovf", int'(bus.count), 16);
        drive(2'b00, 0, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("wrap%0d.free_en", i), int'(bus.free_en), 3);
            check($sformatf("wrap%0d.free_phys0", i), int'(bus.free_phys[0]), 2 * i);
            check($sformatf("wrap%0d.free_phys1", i), int'(bus.free_phys[1]), 2 * i + 1);
            check($sformatf("wrap%0d.count", i), int'(bus.count), 14 - 2 * i);
        end
        tick();
        check("wrap.idle_free_en", int'(bus.free_en), 0);
        check("wrap.empty", int'(bus.empty), 1);

        // Async reset mid-burst with count = 5 and free_en active
        drive(2'b11, 1, 2, 1'b1); tick();
        drive(2'b11, 3, 4, 1'b1); tick();
        drive(2'b01, 5, 0, 1'b1); tick();
        drive(2'b11, 6, 7, 1'b0); tick();
        check("rst.pre_count", int'(bus.count), 5);
        check("rst.pre_free_en", int'(bus.free_en), 3);
        #2;
        reset = 1'b1;
        #1;
        check("rst.free_en", int'(bus.free_en), 0);
        check("rst.free_phys0", int'(bus.free_phys[0]), 0);
        check("rst.count", int'(bus.count), 0);
        check("rst.rel_ready", int'(bus.rel_ready), 1);
        check("rst.empty", int'(bus.empty), 1);
        check("rst.overflow_err", int'(bus.overflow_err), 0);
        check("rst.range_err", int'(bus.range_err), 0);
        drive(2'b00, 0, 0, 1'b0);
        tick();
        check("rst.held_count", int'(bus.count), 0);
        @(negedge clk);
        reset = 1'b0;

        // Double release of tag 42 before it drains
        drive(2'b01, 42, 0, 1'b1); tick();
        drive(2'b01, 42, 0, 1'b1); tick();
        check("dbl.count", int'(bus.count), exp_q2);
        check("dbl.dbl_free_err", int'(bus.dbl_free_err), exp_dbl);
        drive(2'b00, 0, 0, 1'b0);
        hits = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                if (bus.free_en[k] && bus.free_phys[k] == 6'd42) hits++;
            end
        end
        check("dbl.emitted_42", hits, exp_hits);
        check("dbl.empty", int'(bus.empty), 1);

        // Once drained, 42 is releasable again
        drive(2'b01, 42, 0, 1'b0); tick();
        drive(2'b00, 0, 0, 1'b0); tick();
        check("rerel.free_en", int'(bus.free_en), 1);
        check("rerel.free_phys0", int'(bus.free_phys[0]), 42);
        check("rerel.dbl_sticky", int'(bus.dbl_free_err), exp_dbl);

        // Same tag on both lanes in one cycle
        drive(2'b11, 9, 9, 1'b1); tick();
        check("lanedup.count", int'(bus.count), exp_dup_cnt);
        drive(2'b00, 0, 0, 1'b0); tick();
        check("lanedup.free_en", int'(bus.free_en), exp_dup_en);
        check("lanedup.free_phys0", int'(bus.free_phys[0]), 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
